// File: rtl/adc_seq_pkg.sv
// Shared types and ADC interface constants for the MAX10 modular ADC sequencer.
package adc_seq_pkg;

  localparam int ADC_CH_W      = 5;
  localparam int ADC_DATA_W    = 12;
  localparam int ADC_FULL_CODE = 4095;
  localparam int PROD_W        = 25;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WAIT_RSP,
    SCALE,
    STORE
  } state_t;

endpackage

// File: rtl/adc_mv_div.sv
// Sequential restoring divider: one quotient bit per cycle for Q_W cycles.
// The quotient saturates to all ones when it would not fit in Q_W bits.
module adc_mv_div
  import adc_seq_pkg::*;
#(
  parameter int DVD_W = PROD_W,
  parameter int DVS_W = ADC_DATA_W,
  parameter int Q_W   = 13
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Q_W-1:0]   quotient_o
);

  localparam int UP_W  = DVD_W - Q_W;
  localparam int CMP_W = ((UP_W > DVS_W) ? UP_W : DVS_W) + 1;
  localparam int CNT_W = (Q_W > 1) ? $clog2(Q_W) : 1;

  logic [CMP_W-1:0] r_rem;
  logic [Q_W-1:0]   r_low;
  logic [Q_W-1:0]   r_q;
  logic [DVS_W-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_sat;

  logic [CMP_W-1:0] w_upper;
  logic [CMP_W-1:0] w_dvs;
  logic [CMP_W-1:0] w_shift;
  logic             w_ge;
  logic [Q_W-1:0]   w_q_next;

  // Upper dividend bits seed the remainder; if they already reach the divisor
  // the quotient cannot fit in Q_W bits.
  assign w_upper  = CMP_W'(dividend_i[DVD_W-1:Q_W]);
  assign w_dvs    = CMP_W'(r_dvs);
  assign w_shift  = {r_rem[CMP_W-2:0], r_low[Q_W-1]};
  assign w_ge     = (w_shift >= w_dvs);
  assign w_q_next = {r_q[Q_W-2:0], w_ge};

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rem  <= '0;
      r_low  <= '0;
      r_q    <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start_i && !r_busy) begin
        r_rem  <= w_upper;
        r_low  <= dividend_i[Q_W-1:0];
        r_dvs  <= divisor_i;
        r_q    <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
        r_sat  <= (w_upper >= CMP_W'(divisor_i));
      end else if (r_busy) begin
        r_rem <= w_ge ? (w_shift - w_dvs) : w_shift;
        r_low <= {r_low[Q_W-2:0], 1'b0};
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CNT_W'(Q_W - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_q    <= r_sat ? '1 : w_q_next;
        end else begin
          r_q <= w_q_next;
        end
      end
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign quotient_o = r_q;

endmodule

// File: rtl/adc_seq.sv
// Round-robin Avalon-ST command/response sequencer for the MAX10 ADC with mV scaling.
// Define ADC_SEQ_AVG_EN to report a 4-sample running average per slot.
module adc_seq
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH        = 5,
  parameter int FIRST_CH      = 1,
  parameter int FULL_SCALE_MV = 5000,
  parameter int MV_W          = 13,
  parameter int RSP_TIMEOUT   = 1023
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  output logic                   cmd_valid_o,
  output logic [ADC_CH_W-1:0]    cmd_channel_o,
  output logic                   cmd_sop_o,
  output logic                   cmd_eop_o,
  input  logic                   cmd_ready_i,
  input  logic                   rsp_valid_i,
  input  logic [ADC_CH_W-1:0]    rsp_channel_i,
  input  logic [ADC_DATA_W-1:0]  rsp_data_i,
  output logic [NUM_CH*MV_W-1:0] ch_mv_o,
  output logic [NUM_CH-1:0]      ch_update_o,
  output logic                   err_o
);

  localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMO_W  = $clog2(RSP_TIMEOUT + 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [SLOT_W-1:0]     r_slot;
  logic [TMO_W-1:0]      r_tmo;
  logic [ADC_DATA_W-1:0] r_code;
  logic                  r_err;

  logic                  w_rsp_match;
  logic                  w_rsp_mismatch;
  logic                  w_timeout;
  logic                  w_div_start;
  logic                  w_div_busy;
  logic                  w_div_done;
  logic                  w_store;
  logic [MV_W-1:0]       w_div_q;
  logic [PROD_W-1:0]     w_product;
  logic [ADC_DATA_W-1:0] w_divisor;

  assign cmd_channel_o = ADC_CH_W'(FIRST_CH) + ADC_CH_W'(r_slot);
  assign cmd_sop_o     = 1'b1;
  assign cmd_eop_o     = 1'b1;
  assign err_o         = r_err;

  assign w_rsp_match    = (r_state == WAIT_RSP) && rsp_valid_i && (rsp_channel_i == cmd_channel_o);
  assign w_rsp_mismatch = (r_state == WAIT_RSP) && rsp_valid_i && (rsp_channel_i != cmd_channel_o);
  // A response arriving on the timeout cycle still wins.
  assign w_timeout      = (r_state == WAIT_RSP) && !rsp_valid_i && (r_tmo == TMO_W'(RSP_TIMEOUT));
  assign w_store        = (r_state == SCALE) && w_div_done;

  assign w_product = PROD_W'(r_code) * PROD_W'(FULL_SCALE_MV);
  assign w_divisor = ADC_DATA_W'(ADC_FULL_CODE);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    cmd_valid_o  = 1'b0;
    w_div_start  = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable_i) w_state_next = CMD;
      end
      CMD: begin
        cmd_valid_o = 1'b1;
        if (cmd_ready_i) w_state_next = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (w_rsp_match) begin
          w_state_next = SCALE;
        end else if (w_rsp_mismatch || w_timeout) begin
          w_state_next = CMD;
        end
      end
      SCALE: begin
        // Launch exactly once: not while running, not on the done cycle.
        w_div_start = !w_div_busy && !w_div_done;
        if (w_div_done) w_state_next = STORE;
      end
      STORE: begin
        w_state_next = enable_i ? CMD : IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_slot <= '0;
      r_tmo  <= '0;
      r_code <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == WAIT_RSP) begin
        r_tmo <= r_tmo + 1'b1;
      end else begin
        r_tmo <= '0;
      end
      if (w_rsp_match) begin
        r_code <= rsp_data_i;
      end
      if (w_rsp_mismatch || w_timeout) begin
        r_err <= 1'b1;
      end
      if (r_state == STORE) begin
        r_slot <= (r_slot == SLOT_W'(NUM_CH - 1)) ? '0 : r_slot + 1'b1;
      end
    end
  end

  adc_mv_div #(
    .DVD_W(PROD_W),
    .DVS_W(ADC_DATA_W),
    .Q_W  (MV_W)
  ) u_div (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (w_div_start),
    .dividend_i(w_product),
    .divisor_i (w_divisor),
    .busy_o    (w_div_busy),
    .done_o    (w_div_done),
    .quotient_o(w_div_q)
  );

  // Per-slot result registers; the write and update pulse land on the same
  // edge so consumers sampling on the pulse see the new value.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
      logic            w_sel;
      logic [MV_W-1:0] r_mv;
      logic            r_upd;

      assign w_sel = w_store && (r_slot == SLOT_W'(gi));

`ifdef ADC_SEQ_AVG_EN
      localparam int SUM_W = MV_W + 2;
      // Three previous samples; the newest one enters the sum straight from the divider.
      logic [MV_W-1:0]  r_hist [3];
      logic [SUM_W-1:0] w_sum;

      assign w_sum = SUM_W'(w_div_q) + SUM_W'(r_hist[0]) + SUM_W'(r_hist[1]) + SUM_W'(r_hist[2]);

      always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
          r_mv  <= '0;
          r_upd <= 1'b0;
          for (int i = 0; i < 3; i++) begin
            r_hist[i] <= '0;
          end
        end else begin
          r_upd <= w_sel;
          if (w_sel) begin
            r_mv      <= MV_W'(w_sum >> 2);
            r_hist[0] <= w_div_q;
            r_hist[1] <= r_hist[0];
            r_hist[2] <= r_hist[1];
          end
        end
      end
`else
      always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
          r_mv  <= '0;
          r_upd <= 1'b0;
        end else begin
          r_upd <= w_sel;
          if (w_sel) begin
            r_mv <= w_div_q;
          end
        end
      end
`endif

      assign ch_mv_o[gi*MV_W +: MV_W] = r_mv;
      assign ch_update_o[gi]          = r_upd;
    end
  endgenerate

endmodule

// File: tb/tb_adc_seq.sv
// Self-checking bench for adc_seq: table vectors, corner sequences and random
// transactions against an arithmetic scoreboard model.
`timescale 1ns/1ps
module tb_adc_seq;

  localparam int NUM_CH   = 5;
  localparam int FIRST_CH = 1;
  localparam int FS_MV    = 5000;
  localparam int MV_W     = 13;
  localparam int TMO      = 1023;

  logic                   clk;
  logic                   reset_i;
  logic                   enable_i;
  logic                   cmd_valid_o;
  logic [4:0]             cmd_channel_o;
  logic                   cmd_sop_o;
  logic                   cmd_eop_o;
  logic                   cmd_ready_i;
  logic                   rsp_valid_i;
  logic [4:0]             rsp_channel_i;
  logic [11:0]            rsp_data_i;
  logic [NUM_CH*MV_W-1:0] ch_mv_o;
  logic [NUM_CH-1:0]      ch_update_o;
  logic                   err_o;

  adc_seq #(
    .NUM_CH       (NUM_CH),
    .FIRST_CH     (FIRST_CH),
    .FULL_SCALE_MV(FS_MV),
    .MV_W         (MV_W),
    .RSP_TIMEOUT  (TMO)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .cmd_valid_o  (cmd_valid_o),
    .cmd_channel_o(cmd_channel_o),
    .cmd_sop_o    (cmd_sop_o),
    .cmd_eop_o    (cmd_eop_o),
    .cmd_ready_i  (cmd_ready_i),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_channel_i(rsp_channel_i),
    .rsp_data_i   (rsp_data_i),
    .ch_mv_o      (ch_mv_o),
    .ch_update_o  (ch_update_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rdy_dly;
    int rsp_dly;
    int code;
    int exp_ch;
    int exp_mv;
  } vec_t;

  typedef struct {
    int slot;
    int mv;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_slot = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[8];
`ifdef ADC_SEQ_AVG_EN
  int   hist[NUM_CH][3];
`endif

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: floor(code*FS/4095), optionally averaged over the last four samples.
  function automatic int model_store(input int slot, input int code);
    int mv;
`ifdef ADC_SEQ_AVG_EN
    int s;
`endif
    mv = (code * FS_MV) / 4095;
    if (mv > (1 << MV_W) - 1) mv = (1 << MV_W) - 1;
`ifdef ADC_SEQ_AVG_EN
    s = mv + hist[slot][0] + hist[slot][1] + hist[slot][2];
    hist[slot][2] = hist[slot][1];
    hist[slot][1] = hist[slot][0];
    hist[slot][0] = mv;
    return s / 4;
`else
    if (slot < 0) return 0;
    return mv;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_slot = 0;
`ifdef ADC_SEQ_AVG_EN
    for (int s = 0; s < NUM_CH; s++)
      for (int j = 0; j < 3; j++) hist[s][j] = 0;
`endif
  endtask

  // Scoreboard: every update pulse must be one-hot on the expected slot with the expected value.
  always @(negedge clk) begin
    if (reset_i && ch_update_o != '0) begin
      if (exp_q.size() == 0) begin
        check("spurious_update", int'(ch_update_o), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("update_onehot", int'(ch_update_o), 1 << mon_e.slot);
        check("update_mv", int'(ch_mv_o[mon_e.slot*MV_W +: MV_W]), mon_e.mv);
        $display("update slot %0d mv %0d", mon_e.slot, int'(ch_mv_o[mon_e.slot*MV_W +: MV_W]));
      end
    end
  end

  // One ADC transaction. rsp_dly < 0 withholds the response; ch_off != 0 answers on a wrong channel.
  task automatic txn(input int rdy_dly, input int rsp_dly, input int ch_off, input int code,
                     input int exp_ch, input int exp_mv, input bit drop_en);
    int t;
    int ch;
    int m;
    t = 0;
    while (cmd_valid_o !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("cmd_valid_wait", int'(cmd_valid_o), 1);
    if (cmd_valid_o !== 1'b1) return;
    ch = (exp_ch >= 0) ? exp_ch : FIRST_CH + exp_slot;
    check("cmd_channel", int'(cmd_channel_o), ch);
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      check("stall_valid", int'(cmd_valid_o), 1);
      check("stall_channel", int'(cmd_channel_o), ch);
    end
    cmd_ready_i = 1'b1;
    @(negedge clk);
    cmd_ready_i = 1'b0;
    if (drop_en) enable_i = 1'b0;
    if (rsp_dly < 0) return;
    repeat (rsp_dly) @(negedge clk);
    rsp_valid_i   = 1'b1;
    rsp_channel_i = 5'(ch + ch_off);
    rsp_data_i    = 12'(code);
    if (ch_off == 0) begin
      m = model_store(exp_slot, code);
`ifndef ADC_SEQ_AVG_EN
      if (exp_mv >= 0) m = exp_mv;
`endif
      exp_q.push_back('{exp_slot, m});
      exp_slot = (exp_slot + 1) % NUM_CH;
    end
    $display("txn ch %0d code %0d rsp_ch %0d", ch, code, ch + ch_off);
    @(negedge clk);
    rsp_valid_i = 1'b0;
  endtask

  task automatic wait_updates();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("updates_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_valid"}, int'(cmd_valid_o), 0);
    check({tag, "_cmd_channel"}, int'(cmd_channel_o), FIRST_CH);
    check({tag, "_mv_zero"}, int'(ch_mv_o == '0), 1);
    check({tag, "_update"}, int'(ch_update_o), 0);
    check({tag, "_err"}, int'(err_o), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run incomplete, required $finish before 1 ms");
    n_cmp++;
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int t;
    int highs;
    int exp_regs[NUM_CH];
    vecs[0] = '{2, 10, 0,    1, 0};
    vecs[1] = '{2, 10, 819,  2, 1000};
    vecs[2] = '{2, 10, 2048, 3, 2500};
    vecs[3] = '{2, 10, 4095, 4, 5000};
    vecs[4] = '{2, 10, 3276, 5, 4000};
    vecs[5] = '{2, 10, 1,    1, 1};
    vecs[6] = '{0, 0,  4094, 2, 4998};
    vecs[7] = '{1, 3,  2047, 3, 2499};
    exp_regs = '{1, 4998, 2499, 5000, 4000};

    reset_i = 1'b0; enable_i = 1'b0; cmd_ready_i = 1'b0;
    rsp_valid_i = 1'b0; rsp_channel_i = '0; rsp_data_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("sop", int'(cmd_sop_o), 1);
    check("eop", int'(cmd_eop_o), 1);
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_while_disabled", int'(cmd_valid_o), 0);
    enable_i = 1'b1;

    // Round robin ch1..5 then wrap, including exact-boundary codes.
    for (int i = 0; i < 8; i++)
      txn(vecs[i].rdy_dly, vecs[i].rsp_dly, 0, vecs[i].code, vecs[i].exp_ch, vecs[i].exp_mv, 1'b0);
    wait_updates();
`ifndef ADC_SEQ_AVG_EN
    for (int s = 0; s < NUM_CH; s++)
      check("slot_reg", int'(ch_mv_o[s*MV_W +: MV_W]), exp_regs[s]);
`endif
    check("err_clean", int'(err_o), 0);

    // Command held unaccepted for 20 cycles.
    txn(20, 5, 0, 1234, -1, -1, 1'b0);
    wait_updates();

    // enable_i dropped in WAIT_RSP: slot completes, then stays idle; stray response ignored.
    txn(2, 10, 0, 100, -1, -1, 1'b1);
    wait_updates();
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      rsp_valid_i   = (i == 5);
      rsp_channel_i = 5'(FIRST_CH + exp_slot);
      rsp_data_i    = 12'd999;
      @(negedge clk);
      if (cmd_valid_o) highs++;
    end
    rsp_valid_i = 1'b0;
    check("idle_after_disable", highs, 0);
    enable_i = 1'b1;

    // Withheld response: timeout, same channel reissued, later response accepted.
    txn(2, -1, 0, 0, -1, -1, 1'b0);
    t = 0;
    while (!cmd_valid_o && t < 1200) begin
      @(negedge clk);
      t++;
    end
    check("timeout_window", int'(t >= TMO && t <= TMO + 2), 1);
    check("timeout_err", int'(err_o), 1);
    check("timeout_same_ch", int'(cmd_channel_o), FIRST_CH + exp_slot);
    txn(0, 3, 0, 4095, -1, -1, 1'b0);
    wait_updates();

    // Reset clears sticky error.
    reset_i = 1'b0;
    #1;
    check_reset_outputs("reset2");
    @(negedge clk);
    model_reset();
    reset_i = 1'b1;

    // Channel mismatch on ch2: no update, error set, ch2 reissued.
    txn(1, 4, 0, 500, -1, -1, 1'b0);
    txn(1, 4, 1, 2000, 2, -1, 1'b0);
    check("mismatch_err", int'(err_o), 1);
    txn(0, 4, 0, 2000, 2, -1, 1'b0);
    wait_updates();

    // Random traffic against the model.
    for (int i = 0; i < 30; i++)
      txn(int'($urandom_range(0, 4)), int'($urandom_range(0, 12)), 0,
          int'($urandom_range(0, 4095)), -1, -1, 1'b0);
    wait_updates();

    // Asynchronous reset in the middle of SCALE discards the in-flight result.
    txn(0, 2, 0, 3276, -1, -1, 1'b0);
    repeat (4) @(negedge clk);
    reset_i = 1'b0;
    #1;
    check_reset_outputs("reset_scale");
    model_reset();
    @(negedge clk);
    reset_i = 1'b1;
    txn(0, 2, 0, 3276, 1, -1, 1'b0);
    wait_updates();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
